// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
//   state_e        : controller states (IDLE / ADD / DONE)
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   BCD_CORRECTION : value added to a binary digit sum above 9
//   digit_invalid  : helper, true for digit codes 10..15
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_CORRECTION = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake/data bundle for bcd_serial_add_ctrl.
//   master : start, a, b, cin out; busy, done, sum, cout, err in
//   slave  : the controller side (directions reversed)
interface bcd_serial_add_ctrl_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] a;
  logic [BCD_DIGIT_W*DIGITS-1:0] b;
  logic                          cin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] sum;
  logic                          cout;
  logic                          err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder.
//   da, db : operand digits (codes 10..15 are accepted and run through
//            the same rule)
//   c      : carry in
//   d      : result digit
//   co     : carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] da,
  input  logic [BCD_DIGIT_W-1:0] db,
  input  logic                   c,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   co
);

  // 5 bits holds the worst case 15 + 15 + 1 = 31.
  logic [BCD_DIGIT_W:0] s;

  always_comb begin
    s = {1'b0, da} + {1'b0, db} + {{BCD_DIGIT_W{1'b0}}, c};
    if (s > (BCD_DIGIT_W + 1)'(BCD_MAX_DIGIT)) begin
      // Adding in 4 bits gives the mod-16 wrap for free.
      d  = s[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORRECTION);
      co = 1'b1;
    end else begin
      d  = s[BCD_DIGIT_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequenced over one shared digit adder.
// One digit per clock from digit 0 upward, carry chained through a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bcd_serial_add_ctrl_if
//              (start/a/b/cin in, busy/done/sum/cout/err out)
// Optional build macro BCD_INVALID_CHECK_EN: flags operand digits above 9
// on err; without it err is tied low and no check logic exists.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// ADD   | one digit per cycle, busy high
// DONE  | done pulse; sum/cout/err just published
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic                   accept;
  logic                   finish;
  logic [BCD_DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic                   dig_co;

  assign accept = (state_q == IDLE) && bus.start;
  assign finish = (state_q == ADD) && (idx_q == IDX_LAST);

  assign dig_a = opa_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign dig_b = opb_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_digit_add u_digit (
    .da (dig_a),
    .db (dig_b),
    .c  (carry_q),
    .d  (dig_s),
    .co (dig_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        work_d[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_s;
        carry_d = dig_co;
        if (finish) begin
          // Results are published on the edge entering DONE so that they
          // are valid in the same cycle as the done pulse. idx holds here
          // rather than wrapping.
          sum_d   = work_d;
          cout_d  = dig_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef BCD_INVALID_CHECK_EN
  logic err_pend_q, err_pend_d;
  logic err_q, err_d;
  logic in_invalid;

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      in_invalid = in_invalid
                 | digit_invalid(bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                 | digit_invalid(bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  // Flag is taken at accept and published alongside sum.
  always_comb begin
    err_pend_d = accept ? in_invalid : err_pend_q;
    err_d      = finish ? err_pend_q : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = DIGITS + 1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks   = 0;
  int   passed   = 0;
  int   done_cnt = 0;
  logic done_prev = 1'b0;

`ifdef BCD_INVALID_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Reference: decimal integer arithmetic, valid for legal BCD operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t e;
    int va, vb, p, tot;
    logic bad;
    va = 0; vb = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      va  += int'(a[i*4 +: 4]) * p;
      vb  += int'(b[i*4 +: 4]) * p;
      bad |= (a[i*4 +: 4] > 4'd9) | (b[i*4 +: 4] > 4'd9);
      p   *= 10;
    end
    tot    = va + vb + int'(c);
    e.cout = (tot >= p);
    tot    = tot % p;
    e.sum  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.sum[i*4 +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
    e.err = ERR_EN & bad;
    return e;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (done_prev !== 1'b0)
        $display("FAIL done_consecutive: done high two cycles in a row");
      else
        passed++;
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_done: got sum=%h cout=%b err=%b, required no done",
                 bus.sum, bus.cout, bus.err);
      end else begin
        e = sb_q.pop_front();
        if ({bus.sum, bus.cout, bus.err} !== {e.sum, e.cout, e.err})
          $display("FAIL result: got sum=%h cout=%b err=%b, required sum=%h cout=%b err=%b",
                   bus.sum, bus.cout, bus.err, e.sum, e.cout, e.err);
        else
          passed++;
      end
    end
    done_prev = bus.done;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input exp_t e);
    bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called in the cycle after accept; lat counts cycles from accept.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1; busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done); else passed++;
    checks++; if (bus.sum !== '0) $display("FAIL reset_sum: got %h required 0", bus.sum); else passed++;
    checks++; if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b required 0", bus.cout); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b required 0", bus.err); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_timed(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c, input exp_t e);
    int lat, bc;
    issue(a, b, c, e);
    wait_done(lat, bc);
    checks++;
    if (lat !== LAT) $display("FAIL %s_latency: got %0d required %0d", name, lat, LAT);
    else passed++;
    checks++;
    if (bc !== DIGITS) $display("FAIL %s_busy_cycles: got %0d required %0d", name, bc, DIGITS);
    else passed++;
  endtask

  task automatic test_basic();
    exp_t e;
    e.sum = 16'h0000; e.cout = 1'b1; e.err = 1'b0;
    run_timed("carry_chain", 16'h1234, 16'h8766, 1'b0, e);
    e.sum = 16'h0777; e.cout = 1'b0; e.err = 1'b0;
    run_timed("no_carry", 16'h0456, 16'h0321, 1'b0, e);
    e.sum = 16'h0000; e.cout = 1'b1; e.err = 1'b0;
    run_timed("cin_ripple", 16'h9999, 16'h0000, 1'b1, e);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic c;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        a[i*4 +: 4] = 4'($urandom_range(0, 9));
        b[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      c = 1'($urandom_range(0, 1));
      run_timed("random", a, b, c, model(a, b, c));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, bc, d0;
    d0 = done_cnt;
    e.sum = 16'h0010; e.cout = 1'b0; e.err = 1'b0;
    issue(16'h0009, 16'h0001, 1'b0, e);
    @(posedge clk); #1;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== LAT - 2) $display("FAIL b2b_latency: got %0d required %0d", lat, LAT - 2);
    else passed++;
    repeat (DIGITS + 3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int d0;
    d0 = done_cnt;
    e = model(16'h4321, 16'h1111, 1'b0);
    issue(16'h4321, 16'h1111, 1'b0, e);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", bus.busy); else passed++;
    checks++; if (bus.sum !== '0) $display("FAIL midrst_sum: got %h required 0", bus.sum); else passed++;
    checks++; if (bus.cout !== 1'b0) $display("FAIL midrst_cout: got %b required 0", bus.cout); else passed++;
    repeat (DIGITS + 3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) $display("FAIL midrst_no_done: got %0d dones required 0", done_cnt - d0);
    else passed++;
    run_timed("after_rst", 16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0));
  endtask

  task automatic test_invalid_and_hold();
    exp_t e;
    int d0;
    e.sum = 16'h0101; e.cout = 1'b0; e.err = ERR_EN;
    run_timed("invalid", 16'h00A0, 16'h0001, 1'b0, e);
    checks++;
    if (bus.err !== ERR_EN) $display("FAIL invalid_err: got %b required %b", bus.err, ERR_EN);
    else passed++;
    d0 = done_cnt;
    for (int n = 0; n < 10; n++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.sum, bus.cout, bus.err} !== {e.sum, e.cout, e.err})
        $display("FAIL hold: got sum=%h cout=%b err=%b required sum=%h cout=%b err=%b",
                 bus.sum, bus.cout, bus.err, e.sum, e.cout, e.err);
      else
        passed++;
    end
    checks++;
    if (done_cnt !== d0) $display("FAIL hold_done: got %0d dones required 0", done_cnt - d0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_invalid_and_hold();
    checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
